// File: rtl/rs_ooo_pkg.sv
// Shared constants for the out-of-order ALU reservation station.
// Holds default widths and the "no dependency" tag encoding.
// No logic; imported by rs_ooo and rs_age_select.
package rs_ooo_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_IDX_W  = 3;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 5;
    localparam int DEF_OP_W   = 6;

    // A producer tag of zero means the operand value is already present
    localparam int TAG_NONE   = 0;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rs_age_select
    import rs_ooo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic [DEPTH-1:0]            ready,
    // age[i][j] = 1 means entry j is older than entry i
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            gnt,
    output logic [IDX_W-1:0]            gnt_idx,
    output logic                        gnt_any
);

    // An entry wins when it is ready and no older entry is also ready
    always_comb begin
        gnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            gnt[i] = ready[i] && !(|(ready & age[i]));
        end
    end

    // One-hot to binary; the grant is one-hot by construction of the age matrix
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
                gnt_idx = gnt_idx | IDX_W'(i);
            end
        end
        gnt_any = |ready;
    end

endmodule

// File: rtl/rs_ooo.sv
// Reservation station: holds DEPTH ALU ops until both operands resolve, issues oldest ready first.
// Latency: dispatch with ready operands at edge E gives iss_valid at edge E+1.
// Backpressure: disp_ready drops when full; issue register holds while iss_valid && !iss_ready.
module rs_ooo
    import rs_ooo_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [DATA_W-1:0] disp_pc,
    input  logic [DATA_W-1:0] disp_imm,
    input  logic [TAG_W-1:0]  disp_tag,
    input  logic [TAG_W-1:0]  disp_q1,
    input  logic [TAG_W-1:0]  disp_q2,
    input  logic [DATA_W-1:0] disp_v1,
    input  logic [DATA_W-1:0] disp_v2,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [OP_W-1:0]   iss_op,
    output logic [DATA_W-1:0] iss_v1,
    output logic [DATA_W-1:0] iss_v2,
    output logic [DATA_W-1:0] iss_imm,
    output logic [DATA_W-1:0] iss_pc,
    output logic [TAG_W-1:0]  iss_tag,
    output logic [IDX_W:0]    free_cnt
);

    localparam logic [TAG_W-1:0] TAG0     = TAG_W'(TAG_NONE);
    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  tag;
        logic [TAG_W-1:0]  q1;
        logic [TAG_W-1:0]  q2;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
    } entry_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
    } iss_t;

    entry_t                      ent_q [DEPTH];
    entry_t                      ent_d [DEPTH];
    logic [DEPTH-1:0]            busy_q, busy_d;
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    logic                        iss_valid_q, iss_valid_d;
    iss_t                        iss_q, iss_d;
    logic [IDX_W:0]              free_cnt_q, free_cnt_d;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [IDX_W-1:0] alloc_idx;
    logic [DEPTH-1:0] free_mask;
    logic             load_en, issue_fire, disp_fire, cdb_hit;

    assign disp_ready = (free_cnt_q != '0);
    assign free_cnt   = free_cnt_q;
    assign iss_valid  = iss_valid_q;
    assign iss_op     = iss_q.op;
    assign iss_pc     = iss_q.pc;
    assign iss_imm    = iss_q.imm;
    assign iss_tag    = iss_q.tag;
    assign iss_v1     = iss_q.v1;
    assign iss_v2     = iss_q.v2;

    // Ready vector from registered state only, so a wakeup becomes eligible next cycle
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy_q[i] && (ent_q[i].q1 == TAG0) && (ent_q[i].q2 == TAG0);
        end
    end

    rs_age_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sel (
        .ready   (ready),
        .age     (age_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Lowest-index free slot receives the next dispatch
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // Next-state: issue/free, wakeup, dispatch allocation, then flush overrides all
    always_comb begin
        load_en    = !iss_valid_q || iss_ready;
        issue_fire = load_en && gnt_any;
        disp_fire  = disp_valid && disp_ready;
        free_mask  = issue_fire ? gnt : '0;
        cdb_hit    = cdb_valid && (cdb_tag != TAG0);

        ent_d  = ent_q;
        busy_d = busy_q & ~free_mask;
        // Clearing the freed column keeps stale older-than bits from blocking selection
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i] & ~free_mask;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit && (ent_q[i].q1 == cdb_tag)) begin
                ent_d[i].q1 = TAG0;
                ent_d[i].v1 = cdb_data;
            end
            if (cdb_hit && (ent_q[i].q2 == cdb_tag)) begin
                ent_d[i].q2 = TAG0;
                ent_d[i].v2 = cdb_data;
            end
        end

        if (disp_fire) begin
            ent_d[alloc_idx].op  = disp_op;
            ent_d[alloc_idx].pc  = disp_pc;
            ent_d[alloc_idx].imm = disp_imm;
            ent_d[alloc_idx].tag = disp_tag;
            ent_d[alloc_idx].q1  = disp_q1;
            ent_d[alloc_idx].v1  = disp_v1;
            ent_d[alloc_idx].q2  = disp_q2;
            ent_d[alloc_idx].v2  = disp_v2;
            // Same-cycle broadcast of a source producer is captured here
            if (cdb_valid && (disp_q1 != TAG0) && (cdb_tag == disp_q1)) begin
                ent_d[alloc_idx].q1 = TAG0;
                ent_d[alloc_idx].v1 = cdb_data;
            end
            if (cdb_valid && (disp_q2 != TAG0) && (cdb_tag == disp_q2)) begin
                ent_d[alloc_idx].q2 = TAG0;
                ent_d[alloc_idx].v2 = cdb_data;
            end
            busy_d[alloc_idx] = 1'b1;
            // Everything still resident after this edge is older than the newcomer
            age_d[alloc_idx]  = busy_q & ~free_mask;
        end

        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;
        if (load_en) begin
            iss_valid_d = gnt_any;
            if (gnt_any) begin
                iss_d.op  = ent_q[gnt_idx].op;
                iss_d.pc  = ent_q[gnt_idx].pc;
                iss_d.imm = ent_q[gnt_idx].imm;
                iss_d.tag = ent_q[gnt_idx].tag;
                iss_d.v1  = ent_q[gnt_idx].v1;
                iss_d.v2  = ent_q[gnt_idx].v2;
            end
        end

        free_cnt_d = free_cnt_q + (IDX_W+1)'(issue_fire) - (IDX_W+1)'(disp_fire);

        if (flush) begin
            busy_d      = '0;
            age_d       = '0;
            iss_valid_d = 1'b0;
            iss_d       = iss_q;
            free_cnt_d  = CNT_FULL;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            age_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            free_cnt_q  <= CNT_FULL;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            age_q       <= age_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            free_cnt_q  <= free_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_ooo.sv
// Scoreboard bench for rs_ooo: a queue-ordered reference model predicts each issued op.
// Directed scenarios followed by randomized dispatch/broadcast/flush traffic and a mid-run reset.
// Monitor on the falling edge compares every accepted issue and the occupancy outputs.
module tb_rs_ooo;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int OP_W   = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              disp_valid = 1'b0;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op = '0;
    logic [DATA_W-1:0] disp_pc = '0, disp_imm = '0, disp_v1 = '0, disp_v2 = '0;
    logic [TAG_W-1:0]  disp_tag = '0, disp_q1 = '0, disp_q2 = '0;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              iss_valid;
    logic              iss_ready = 1'b1;
    logic [OP_W-1:0]   iss_op;
    logic [DATA_W-1:0] iss_v1, iss_v2, iss_imm, iss_pc;
    logic [TAG_W-1:0]  iss_tag;
    logic [IDX_W:0]    free_cnt;

    rs_ooo #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_tag(disp_tag),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_imm(iss_imm),
        .iss_pc(iss_pc), .iss_tag(iss_tag), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] pc, imm, v1, v2;
        logic [TAG_W-1:0]  tag, q1, q2;
    } ins_t;

    // Reference model: resident instructions kept oldest-first in a queue
    ins_t win[$];
    ins_t exp_q[$];
    bit   m_iss_vld = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        exp_q.delete();
        m_iss_vld = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at that edge
    task automatic model_step();
        bit   can_disp;
        bit   load;
        int   k;
        ins_t n;
        if (flush) begin
            if (m_iss_vld && !iss_ready && exp_q.size() > 0) void'(exp_q.pop_back());
            win.delete();
            m_iss_vld = 1'b0;
            return;
        end
        can_disp = (win.size() < DEPTH);
        load     = !m_iss_vld || iss_ready;
        if (load) begin
            k = -1;
            for (int i = 0; i < win.size(); i++) begin
                if (k < 0 && win[i].q1 == '0 && win[i].q2 == '0) k = i;
            end
            if (k >= 0) begin
                exp_q.push_back(win[k]);
                win.delete(k);
                m_iss_vld = 1'b1;
            end else begin
                m_iss_vld = 1'b0;
            end
        end
        if (cdb_valid && cdb_tag != '0) begin
            for (int i = 0; i < win.size(); i++) begin
                if (win[i].q1 == cdb_tag) begin win[i].q1 = '0; win[i].v1 = cdb_data; end
                if (win[i].q2 == cdb_tag) begin win[i].q2 = '0; win[i].v2 = cdb_data; end
            end
        end
        if (disp_valid && can_disp) begin
            n.op = disp_op; n.pc = disp_pc; n.imm = disp_imm; n.tag = disp_tag;
            n.q1 = disp_q1; n.v1 = disp_v1; n.q2 = disp_q2; n.v2 = disp_v2;
            if (cdb_valid && disp_q1 != '0 && cdb_tag == disp_q1) begin n.q1 = '0; n.v1 = cdb_data; end
            if (cdb_valid && disp_q2 != '0 && cdb_tag == disp_q2) begin n.q2 = '0; n.v2 = cdb_data; end
            win.push_back(n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] q1,
                        input logic [TAG_W-1:0] q2, input logic [DATA_W-1:0] v1,
                        input logic [DATA_W-1:0] v2);
        disp_valid = 1'b1;
        disp_op    = OP_W'($urandom_range(0, 63));
        disp_pc    = $urandom;
        disp_imm   = $urandom;
        disp_tag   = tag;
        disp_q1    = q1;
        disp_q2    = q2;
        disp_v1    = v1;
        disp_v2    = v2;
    endtask

    task automatic rand_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            iss_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1)
                disp(TAG_W'($urandom_range(1, 31)),
                     ($urandom_range(0, 2) == 0) ? TAG_W'(0) : TAG_W'($urandom_range(1, 7)),
                     ($urandom_range(0, 2) == 0) ? TAG_W'(0) : TAG_W'($urandom_range(1, 7)),
                     $urandom, $urandom);
            else
                disp_valid = 1'b0;
            cdb_valid = ($urandom_range(0, 1) == 1);
            cdb_tag   = TAG_W'($urandom_range(0, 7));
            cdb_data  = $urandom;
            step();
        end
        idle();
    endtask

    // Monitor: occupancy each cycle, plus one scoreboard pop per accepted issue
    bit                stall = 1'b0;
    logic [DATA_W-1:0] h_v1, h_v2;
    logic [TAG_W-1:0]  h_tag;
    ins_t              e;

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            chk("free_cnt", 64'(free_cnt), 64'(DEPTH - win.size()));
            chk("disp_ready", 64'(disp_ready), 64'(win.size() < DEPTH));
            chk("iss_valid", 64'(iss_valid), 64'(m_iss_vld));
            if (stall && iss_valid) begin
                chk("hold_v1", 64'(iss_v1), 64'(h_v1));
                chk("hold_v2", 64'(iss_v2), 64'(h_v2));
                chk("hold_tag", 64'(iss_tag), 64'(h_tag));
            end
            if (iss_valid && iss_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 64'(iss_tag), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("iss_op", 64'(iss_op), 64'(e.op));
                    chk("iss_v1", 64'(iss_v1), 64'(e.v1));
                    chk("iss_v2", 64'(iss_v2), 64'(e.v2));
                    chk("iss_imm", 64'(iss_imm), 64'(e.imm));
                    chk("iss_pc", 64'(iss_pc), 64'(e.pc));
                    chk("iss_tag", 64'(iss_tag), 64'(e.tag));
                end
            end
            stall = iss_valid && !iss_ready;
            h_v1  = iss_v1;
            h_v2  = iss_v2;
            h_tag = iss_tag;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Single ready op: issues one edge after dispatch
        iss_ready = 1'b1;
        disp(5'd4, 5'd0, 5'd0, 32'd5, 32'd7);
        disp_op = 6'd3;
        step();
        idle();
        repeat (3) step();

        // Two ops waiting on tag 9, woken together; oldest goes first
        disp(5'd1, 5'd9, 5'd0, 32'd0, 32'd11);
        step();
        disp(5'd2, 5'd9, 5'd0, 32'd0, 32'd22);
        step();
        idle();
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h55;
        step();
        idle();
        repeat (4) step();

        // Dispatch-time bypass of a same-cycle broadcast
        disp(5'd12, 5'd0, 5'd6, 32'd1, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_data = 32'hAB;
        step();
        idle();
        repeat (3) step();

        // Fill to full with a ninth attempt, then release all on tag 3
        for (int i = 0; i < 9; i++) begin
            disp(5'(i + 16), 5'd3, 5'd0, 32'd0, 32'(i));
            step();
        end
        idle();
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'h33;
        step();
        idle();
        repeat (11) step();

        // Stalled issue with two ready entries, then release
        iss_ready = 1'b0;
        disp(5'd7, 5'd0, 5'd0, 32'h70, 32'h71);
        step();
        disp(5'd8, 5'd0, 5'd0, 32'h80, 32'h81);
        step();
        idle();
        repeat (4) step();
        iss_ready = 1'b1;
        repeat (4) step();

        // Flush with five resident entries and a held issue, plus a colliding dispatch
        iss_ready = 1'b0;
        disp(5'd10, 5'd0, 5'd0, 32'd1, 32'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            disp(5'(i + 20), 5'd7, 5'd0, 32'd0, 32'd0);
            step();
        end
        disp(5'd30, 5'd0, 5'd0, 32'd9, 32'd9);
        flush = 1'b1;
        step();
        idle();
        iss_ready = 1'b1;
        repeat (3) step();

        rand_cycles(1500);

        // Asynchronous reset mid-traffic: outputs must return to reset values at once
        rand_cycles(20);
        #2 rst = 1'b1;
        #1;
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_free_cnt", 64'(free_cnt), 64'(DEPTH));
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_iss_v1", 64'(iss_v1), 64'd0);
        chk("rst_iss_tag", 64'(iss_tag), 64'd0);
        chk("rst_iss_op", 64'(iss_op), 64'd0);
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();

        rand_cycles(1500);

        // Drain: a flush leaves nothing outstanding in the scoreboard
        flush = 1'b1;
        step();
        idle();
        repeat (2) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_ooo.md
Name: rs_ooo

Overview:
- Parametrised reservation station for the out-of-order ALU path; successor to the fixed 8-entry station.
- Sits between decode/rename and the ALU. Holds DEPTH instructions until both source operands are resolved.
- Captures operands from the commit broadcast, including a same-cycle bypass at dispatch.
- Issues the oldest ready entry through a valid/ready handshake, replacing the old lowest-index-first pick.

Parameters:
- DEPTH, 8, number of entries (power of two, 2..32)
- IDX_W, 3, log2(DEPTH)
- DATA_W, 32, operand/immediate/pc width
- TAG_W, 5, ROB tag width; tag 0 means "no dependency"
- OP_W, 6, opcode width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  exception/mispredict flush from ROB
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_op  in  OP_W  opcode
- disp_pc  in  DATA_W  instruction pc
- disp_imm  in  DATA_W  immediate
- disp_tag  in  TAG_W  ROB tag of this instruction
- disp_q1, disp_q2  in  TAG_W  source producer tags (0 = value valid)
- disp_v1, disp_v2  in  DATA_W  source values when q = 0
- cdb_valid  in  1  commit broadcast valid
- cdb_tag  in  TAG_W  broadcast producer tag
- cdb_data  in  DATA_W  broadcast result
- iss_valid  out  1  issue slot holds an instruction
- iss_ready  in  1  ALU accepts
- iss_op  out  OP_W  issued opcode
- iss_v1, iss_v2, iss_imm, iss_pc  out  DATA_W  issued operands
- iss_tag  out  TAG_W  issued ROB tag
- free_cnt  out  IDX_W+1  number of free entries

Behaviour:
- Reset (async): all entries not busy; age matrix cleared; iss_valid=0; all iss_* data=0; free_cnt=DEPTH; disp_ready=1.
- disp_ready = (free_cnt != 0), from registered state only. It ignores an issue happening in the same cycle.
- Dispatch fires when disp_valid && disp_ready. The instruction is written to the lowest-index free entry; age row set = all currently busy entries (older than the new one).
- Dispatch bypass: if cdb_valid && cdb_tag == disp_qN && disp_qN != 0, the entry stores Q=0 and V=cdb_data. Otherwise it stores disp_qN/disp_vN.
- Wakeup: every cycle with cdb_valid and cdb_tag != 0, each busy entry with Qn == cdb_tag sets Qn=0 and Vn=cdb_data. Both sources may wake in the same cycle.
- Ready(entry) = busy && Q1==0 && Q2==0, evaluated on registered state. A CDB wakeup in cycle N makes the entry eligible in cycle N+1.
- Select: among ready entries, pick the one older than every other ready entry (age matrix). Ties are impossible.
- Issue register: loads when !iss_valid || iss_ready. If a ready entry exists, it loads that entry, sets iss_valid=1 and frees the entry at the same edge. Otherwise it clears iss_valid.
- While iss_valid && !iss_ready, the iss_* outputs hold stable and no entry is freed.
- Minimum latency: dispatch with both operands ready at edge E -> iss_valid at edge E+1.
- Throughput: 1 dispatch + 1 issue per cycle. With simultaneous dispatch and issue, free_cnt is unchanged.
- free_cnt = DEPTH - busy count, registered.
- Full: disp_ready=0. A disp_valid while full is ignored and causes no state change.
- Flush: synchronous. At the next edge all entries are cleared and iss_valid=0. Dispatch, wakeup and issue in that cycle are discarded. Flush takes priority over everything.
- Reset asserted mid-operation clears immediately (async). Outputs remain at reset values until the first edge after deassert.
- Age matrix: an entry's row bit j is cleared when entry j is freed. Stale bits must never block selection.

Decomposition:
- Shared package (parameters.v style defines): TAG_NONE=0, default widths, opcode width.
- One natural sub-module: rs_age_select. It takes the ready vector and age matrix and returns a one-hot grant plus encoded index; purely combinational.
- Entry storage, wakeup, dispatch allocation and the issue register live in rs_ooo.

Test Plan:
- Reset, then dispatch op=3, q1=q2=0, v1=5, v2=7, tag=4, iss_ready=1 -> next cycle iss_valid=1, iss_v1=5, iss_v2=7, iss_tag=4; free_cnt returns to 8.
- Dispatch A (tag 1, q1=9) then B (tag 2, q1=9); CDB tag 9 data 0x55 -> A issues first with v1=0x55, B the following cycle (oldest-first despite index order).
- Dispatch with q2=6 in the same cycle as cdb_valid, tag 6, data 0xAB -> entry stored ready; issues next cycle with iss_v2=0xAB.
- Fill all 8 entries with q1=3 -> disp_ready=0, free_cnt=0; a 9th disp_valid is ignored. CDB tag 3 -> issues drain in dispatch order.
- iss_ready=0 for 4 cycles with 2 ready entries -> iss_* stable, free_cnt unchanged. iss_ready=1 -> the two entries issue on consecutive cycles.
- 5 busy entries plus iss_valid=1; assert flush together with disp_valid -> next cycle free_cnt=8, iss_valid=0, dispatched instruction absent. Async rst mid-run -> outputs at reset values immediately.
